ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 25 ++
 rtl/ram_arbiter_if.sv | 17 +
 rtl/ram_arbiter_rr_pick2.sv | 18 +
 rtl/ram_arbiter.sv | 136 +++++++++++++
 tb/tb_ram_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-requester RAM arbiter: FSM encoding,
// requester indices and the legal range of the RAM read latency.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int REQ_CU      = 0;
    localparam int REQ_LOADER  = 1;
    localparam int RAM_LAT_MIN = 1;
    localparam int RAM_LAT_MAX = 4;
    localparam int CNT_W       = 2;

    // WAIT down-counter load value; out-of-range latencies are clamped.
    function automatic logic [CNT_W-1:0] wait_load(input int lat);
        if (lat < RAM_LAT_MIN) return '0;
        if (lat > RAM_LAT_MAX) return CNT_W'(RAM_LAT_MAX - 1);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter; both requesters share one bundle,
// indexed by requester number.
interface ram_arbiter_if #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 8
);
    logic [1:0]             req;
    logic [1:0]             we;
    logic [1:0][AWIDTH-1:0] addr;
    logic [1:0][DWIDTH-1:0] wdata;
    logic [1:0]             gnt;
    logic [1:0]             rvalid;
    logic [DWIDTH-1:0]      rdata;

    modport slave  (input  req, we, addr, wdata, output gnt, rvalid, rdata);
    modport master (output req, we, addr, wdata, input  gnt, rvalid, rdata);
endinterface

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin winner pick: a sole requester wins, on a tie the
// requester not served last wins.
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       any
);
    always_comb begin
        any    = |req;
        winner = 1'(REQ_CU);
        if (req[REQ_LOADER] && (!req[REQ_CU] || last == 1'(REQ_CU))) begin
            winner = 1'(REQ_LOADER);
        end
    end
endmodule

// File: rtl/ram_arbiter.sv
// Two-requester single-port RAM arbiter (IDLE->ISSUE->WAIT->DONE).
// Optional loader bus lock enabled by defining RAM_ARBITER_LOCK_EN.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DWIDTH  = 16,
    parameter int AWIDTH  = 8,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
`ifdef RAM_ARBITER_LOCK_EN
    input  logic              lock,
`endif
    ram_arbiter_if.slave      bus,
    output logic              ram_en,
    output logic              ram_we,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_wdata,
    input  logic [DWIDTH-1:0] ram_rdata,
    output logic              busy
);
    state_t            state_q, state_d;
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              locked_q, locked_d;
    logic              eff_last;
    logic              pick_win, pick_any;
    logic [1:0]        gnt, rvalid;

`ifdef RAM_ARBITER_LOCK_EN
    // While locked, pretend requester 0 was served last so the loader keeps winning ties.
    assign eff_last = (locked_q && lock) ? 1'(REQ_CU) : last_q;
`else
    assign eff_last = last_q;
`endif

    rr_pick2 u_pick (
        .req    (bus.req),
        .last   (eff_last),
        .winner (pick_win),
        .any    (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        locked_d  = locked_q;
        gnt       = 2'b00;
        rvalid    = 2'b00;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
`ifdef RAM_ARBITER_LOCK_EN
        if (!lock) locked_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = ISSUE;
                    win_d   = pick_win;
                    we_d    = bus.we[pick_win];
                    addr_d  = bus.addr[pick_win];
                    wdata_d = bus.wdata[pick_win];
`ifdef RAM_ARBITER_LOCK_EN
                    if (lock && pick_win == 1'(REQ_LOADER)) locked_d = 1'b1;
`endif
                end
            end
            ISSUE: begin
                ram_en       = 1'b1;
                ram_we       = we_q;
                ram_addr     = addr_q;
                ram_wdata    = wdata_q;
                gnt[win_q]   = 1'b1;
                last_d       = win_q;
                cnt_d        = wait_load(RAM_LAT);
                state_d      = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (!we_q) rdata_d = ram_rdata;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                rvalid[win_q] = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            win_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            last_q   <= 1'(REQ_LOADER);
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign bus.gnt    = gnt;
    assign bus.rvalid = rvalid;
    assign bus.rdata  = rdata_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a RAM_LAT=1 instance driven from a vector
// table plus hand sequences, and a RAM_LAT=3 instance for latency scaling.
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ram_arbiter_if #(.DWIDTH(16), .AWIDTH(8)) b1 ();
    ram_arbiter_if #(.DWIDTH(16), .AWIDTH(8)) b3 ();

    logic        ram_en1, ram_we1, busy1, ram_en3, ram_we3, busy3;
    logic [7:0]  ram_addr1, ram_addr3;
    logic [15:0] ram_wdata1, ram_rdata1, ram_wdata3, ram_rdata3;
`ifdef RAM_ARBITER_LOCK_EN
    logic lock = 1'b0;
`endif

    ram_arbiter #(.DWIDTH(16), .AWIDTH(8), .RAM_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
`ifdef RAM_ARBITER_LOCK_EN
        .lock(lock),
`endif
        .bus(b1.slave), .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1),
        .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1), .busy(busy1));

    ram_arbiter #(.DWIDTH(16), .AWIDTH(8), .RAM_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
`ifdef RAM_ARBITER_LOCK_EN
        .lock(1'b0),
`endif
        .bus(b3.slave), .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3),
        .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3), .busy(busy3));

    // RAM models: address 0x10 preloaded with 0xBEEF, read data after 1 / 3 cycles
    logic [15:0] mem1 [256];
    logic [15:0] mem3 [256];
    logic [15:0] pipe1;
    logic [15:0] pipe3 [3];
    always @(posedge clk) begin
        if (rst) begin
            mem1[8'h10] <= 16'hBEEF;
        end else if (ram_en1) begin
            if (ram_we1) mem1[ram_addr1] <= ram_wdata1;
            pipe1 <= mem1[ram_addr1];
        end
    end
    always @(posedge clk) begin
        if (rst) mem3[8'h10] <= 16'hBEEF;
        else if (ram_en3 && ram_we3) mem3[ram_addr3] <= ram_wdata3;
        pipe3[0] <= mem3[ram_addr3];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign ram_rdata1 = pipe1;
    assign ram_rdata3 = pipe3[2];

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [7:0]  a0, a1;
        logic [15:0] d0, d1;
        logic [1:0]  e_gnt;
        logic        e_we;
        logic [7:0]  e_addr;
        logic [15:0] e_wdata;
        logic [15:0] e_rdata;
    } vec_t;
    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle1();
        int k = 0;
        while (busy1 && k < 20) begin tick(); k++; end
        chk("idle_timeout", 32'(busy1), 0);
    endtask

    // One full transaction on the RAM_LAT=1 instance, checked cycle by cycle.
    task automatic apply(input int idx, input vec_t v);
        b1.req = v.req; b1.we = v.we;
        b1.addr[0] = v.a0; b1.addr[1] = v.a1;
        b1.wdata[0] = v.d0; b1.wdata[1] = v.d1;
        tick();
        chk("issue_gnt", 32'(b1.gnt), 32'(v.e_gnt));
        chk("issue_en", 32'(ram_en1), 1);
        chk("issue_we", 32'(ram_we1), 32'(v.e_we));
        chk("issue_addr", 32'(ram_addr1), 32'(v.e_addr));
        chk("issue_wdata", 32'(ram_wdata1), 32'(v.e_wdata));
        chk("issue_busy", 32'(busy1), 1);
        b1.req = 2'b00;
        tick();
        chk("wait_en", 32'(ram_en1), 0);
        chk("wait_gnt_rvalid", {b1.gnt, b1.rvalid}, 0);
        tick();
        chk("done_rvalid", 32'(b1.rvalid), 32'(v.e_gnt));
        chk("done_rdata", 32'(b1.rdata), 32'(v.e_rdata));
        tick();
        chk("idle_busy", 32'(busy1), 0);
        $display("txn %0d: req=%b we=%b gnt=%b addr=%h rdata=%h", idx, v.req, v.we, v.e_gnt, v.e_addr, b1.rdata);
    endtask

    initial begin
        logic       gw [4];
        int         gc [4];
        int         ng, k, en_cnt, g_at, v_at, rv_seen;

        b1.req = 0; b1.we = 0; b1.addr = '0; b1.wdata = '0;
        b3.req = 0; b3.we = 0; b3.addr = '0; b3.wdata = '0;

        //          req    we     a0     a1     d0        d1        gnt    we    addr   wdata     rdata
        vecs[0] = '{2'b01, 2'b00, 8'h10, 8'h00, 16'h0000, 16'h0000, 2'b01, 1'b0, 8'h10, 16'h0000, 16'hBEEF};
        vecs[1] = '{2'b10, 2'b10, 8'h00, 8'h05, 16'h0000, 16'h1234, 2'b10, 1'b1, 8'h05, 16'h1234, 16'hBEEF};
        vecs[2] = '{2'b10, 2'b00, 8'h00, 8'h05, 16'h0000, 16'h0000, 2'b10, 1'b0, 8'h05, 16'h0000, 16'h1234};
        vecs[3] = '{2'b11, 2'b01, 8'h20, 8'h30, 16'hAAAA, 16'h0000, 2'b01, 1'b1, 8'h20, 16'hAAAA, 16'h1234};
        vecs[4] = '{2'b11, 2'b00, 8'h77, 8'h20, 16'h0000, 16'h0000, 2'b10, 1'b0, 8'h20, 16'h0000, 16'hAAAA};
        vecs[5] = '{2'b01, 2'b01, 8'hFF, 8'h00, 16'h5555, 16'h0000, 2'b01, 1'b1, 8'hFF, 16'h5555, 16'hAAAA};
        vecs[6] = '{2'b10, 2'b00, 8'h00, 8'hFF, 16'h0000, 16'h0000, 2'b10, 1'b0, 8'hFF, 16'h0000, 16'h5555};
        vecs[7] = '{2'b11, 2'b11, 8'h40, 8'h41, 16'h1111, 16'h2222, 2'b01, 1'b1, 8'h40, 16'h1111, 16'h5555};
        vecs[8] = '{2'b11, 2'b00, 8'h41, 8'h40, 16'h0000, 16'h0000, 2'b10, 1'b0, 8'h40, 16'h0000, 16'h1111};

        // Reset state
        tick(); tick();
        chk("rst_outputs1", {b1.gnt, b1.rvalid, ram_en1, ram_we1, busy1}, 0);
        chk("rst_bus1", {ram_addr1, ram_wdata1, b1.rdata}, 0);
        chk("rst_outputs3", {b3.gnt, b3.rvalid, ram_en3, busy3, b3.rdata}, 0);

        // First vector applied in the cycle reset drops: granted on the first edge
        rst = 1'b0;
        for (int i = 0; i < 9; i++) apply(i, vecs[i]);

        // Round-robin under contention, last served = 1 now
        b1.req = 2'b11; b1.we = 2'b00; b1.addr[0] = 8'h10; b1.addr[1] = 8'h10;
        ng = 0; k = 0;
        while (ng < 4 && k < 40) begin
            tick(); k++;
            chk("rr_onehot", 32'(b1.gnt == 2'b11), 0);
            if (b1.gnt != 2'b00) begin
                gw[ng] = b1.gnt[1]; gc[ng] = cyc; ng++;
                if (ng == 4) b1.req = 2'b00;
            end
        end
        b1.req = 2'b00;
        chk("rr_count", ng, 4);
        for (int i = 0; i < 4 && i < ng; i++) begin
            chk($sformatf("rr_order%0d", i), 32'(gw[i]), 32'(i % 2));
            if (i > 0) chk($sformatf("rr_space%0d", i), gc[i] - gc[i-1], 4);
        end
        $display("txn rr: %0d grants under req=11", ng);
        wait_idle1();

        // Latency scaling on the RAM_LAT=3 instance
        b3.req = 2'b01; b3.addr[0] = 8'h10;
        en_cnt = 0; g_at = -1; v_at = -1;
        for (int j = 1; j <= 10; j++) begin
            tick();
            if (ram_en3) en_cnt++;
            if (b3.gnt == 2'b01 && g_at < 0) g_at = j;
            if (b3.rvalid == 2'b01 && v_at < 0) begin
                v_at = j;
                chk("lat3_rdata", 32'(b3.rdata), 32'h0000BEEF);
            end
            b3.req = 2'b00;
        end
        chk("lat3_gnt_at", g_at, 1);
        chk("lat3_rvalid_at", v_at, 5);
        chk("lat3_en_cycles", en_cnt, 1);
        $display("txn lat3: gnt at +%0d rvalid at +%0d", g_at, v_at);

        // Reset pulsed mid-WAIT
        b1.req = 2'b01; b1.we = 2'b00; b1.addr[0] = 8'h10;
        tick();
        b1.req = 2'b00;
        tick();
        chk("rstw_busy_before", 32'(busy1), 1);
        rst = 1'b1;
        #1;
        chk("rstw_outputs", {b1.gnt, b1.rvalid, ram_en1, ram_we1, busy1}, 0);
        chk("rstw_rdata", 32'(b1.rdata), 0);
        tick();
        rst = 1'b0;
        rv_seen = 0;
        for (int j = 0; j < 6; j++) begin
            tick();
            if (b1.rvalid != 2'b00) rv_seen++;
        end
        chk("rstw_no_rvalid", rv_seen, 0);
        $display("txn rst_wait: aborted, %0d stray rvalid", rv_seen);
        apply(9, vecs[0]);

`ifdef RAM_ARBITER_LOCK_EN
        // last served = 0, so the loader wins the first tie and then holds it under lock
        lock = 1'b1;
        b1.req = 2'b11; b1.we = 2'b00; b1.addr[0] = 8'h10; b1.addr[1] = 8'h10;
        ng = 0; k = 0;
        while (ng < 4 && k < 40) begin
            tick(); k++;
            if (b1.gnt != 2'b00) begin
                gw[ng] = b1.gnt[1]; ng++;
                if (ng == 3) lock = 1'b0;
                if (ng == 4) b1.req = 2'b00;
            end
        end
        b1.req = 2'b00;
        chk("lock_count", ng, 4);
        for (int i = 0; i < 4 && i < ng; i++)
            chk($sformatf("lock_order%0d", i), 32'(gw[i]), (i < 3) ? 1 : 0);
        $display("txn lock: %0d grants", ng);
        wait_idle1();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
